// File: rtl/vec_ram_mrp.sv
// vec_ram_mrp: NRD-read / 1-write lane-strobed vector RAM with a built-in clear engine.
// Optional macro VRAM_FWD_EN: write-first forwarding of strobed lanes to same-cycle reads.

module vec_ram_mrp_rport #(
    parameter int W        = 512,
    parameter int READ_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req,
    input  logic [W-1:0] word,
    output logic         rvalid,
    output logic [W-1:0] rdata
);
    logic [READ_LAT:1] vld_pipe;
    logic [W-1:0]      q1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            q1       <= '0;
        end else begin
            vld_pipe <= READ_LAT'({vld_pipe, req});
            if (req) q1 <= word;
        end
    end

    // The output register only loads on a completing read, so data holds between reads.
    if (READ_LAT == 2) begin : g_lat2
        logic [W-1:0] q2;
        always_ff @(posedge clk) begin
            if (!rst_n)          q2 <= '0;
            else if (vld_pipe[1]) q2 <= q1;
        end
        assign rdata = q2;
    end else begin : g_lat1
        assign rdata = q1;
    end

    assign rvalid = vld_pipe[READ_LAT];
endmodule

module vec_ram_mrp #(
    parameter int DEPTH      = 2048,
    parameter int AW         = $clog2(DEPTH),
    parameter int LANES      = 16,
    parameter int LANE_W     = 32,
    parameter int NRD        = 3,
    parameter int READ_LAT   = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr_req,
    output logic                          busy,
    input  logic                          wen,
    input  logic [AW-1:0]                 waddr,
    input  logic [LANES*LANE_W-1:0]       wdata,
    input  logic [LANES-1:0]              wstrb,
    input  logic [NRD-1:0]                rd_en,
    input  logic [NRD*AW-1:0]             raddr,
    output logic [NRD-1:0]                rvalid,
    output logic [NRD*LANES*LANE_W-1:0]   rdata
);
    localparam int            VW   = LANES * LANE_W;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state, state_nxt;
    logic          run;
    logic [AW-1:0] clr_ptr;
    logic          idle;
    logic          w_in;
    logic          wr_ok;
    logic [VW-1:0] mem [DEPTH];

    // run holds the clear engine for one cycle after reset so busy is low while rst_n is low.
    assign busy  = (state == CLEAR) && run;
    assign idle  = (state == IDLE);
    assign wr_ok = wen && idle && w_in;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = CLEAR;
            CLEAR:   if (run && clr_ptr == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
            run     <= 1'b0;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
            if (busy) clr_ptr <= (clr_ptr == LAST) ? '0 : clr_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_ptr] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < LANES; i++)
                if (wstrb[i]) mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
    end

    if (DEPTH == (1 << AW)) begin : g_wpow2
        assign w_in = 1'b1;
    end else begin : g_wnpow2
        assign w_in = ({1'b0, waddr} < (AW+1)'(DEPTH));
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        logic [AW-1:0] a;
        logic          hit;
        logic [VW-1:0] old;
        logic [VW-1:0] word;

        assign a = raddr[p*AW +: AW];

        if (DEPTH == (1 << AW)) begin : g_rpow2
            assign hit = 1'b1;
        end else begin : g_rnpow2
            assign hit = ({1'b0, a} < (AW+1)'(DEPTH));
        end

        assign old = hit ? mem[a] : '0;

`ifdef VRAM_FWD_EN
        always_comb begin
            word = old;
            if (wr_ok && waddr == a) begin
                for (int i = 0; i < LANES; i++)
                    if (wstrb[i]) word[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
            end
        end
`else
        assign word = old;
`endif

        vec_ram_mrp_rport #(.W(VW), .READ_LAT(READ_LAT)) u_rport (
            .clk    (clk),
            .rst_n  (rst_n),
            .req    (rd_en[p] && idle),
            .word   (word),
            .rvalid (rvalid[p]),
            .rdata  (rdata[p*VW +: VW])
        );
    end
endmodule

// File: tb/tb_vec_ram_mrp.sv
// Bench for vec_ram_mrp: DEPTH=16, two instances (READ_LAT=1 and 2) driven in lockstep.
module tb_vec_ram_mrp;
    localparam int DEPTH = 16, AW = 4, LANES = 16, LANE_W = 32, NRD = 3;
    localparam int VW = LANES * LANE_W;
`ifdef VRAM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef logic [VW-1:0] vec_t;
    typedef struct {
        logic [AW-1:0] a0, a1, a2;
        vec_t          e0, e1, e2;
    } rvec_t;

    logic              clk = 1'b0, rst_n = 1'b0, clr_req = 1'b0, wen = 1'b0;
    logic [AW-1:0]     waddr = '0;
    vec_t              wdata = '0;
    logic [LANES-1:0]  wstrb = '0;
    logic [NRD-1:0]    rd_en = '0;
    logic [NRD*AW-1:0] raddr = '0;
    logic              busy1, busy2;
    logic [NRD-1:0]    rvalid1, rvalid2;
    logic [NRD*VW-1:0] rdata1, rdata2;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    vec_ram_mrp #(.DEPTH(DEPTH), .AW(AW), .LANES(LANES), .LANE_W(LANE_W), .NRD(NRD),
                  .READ_LAT(1), .CLR_ON_RST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy1), .wen(wen), .waddr(waddr),
        .wdata(wdata), .wstrb(wstrb), .rd_en(rd_en), .raddr(raddr), .rvalid(rvalid1), .rdata(rdata1));

    vec_ram_mrp #(.DEPTH(DEPTH), .AW(AW), .LANES(LANES), .LANE_W(LANE_W), .NRD(NRD),
                  .READ_LAT(2), .CLR_ON_RST(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy2), .wen(wen), .waddr(waddr),
        .wdata(wdata), .wstrb(wstrb), .rd_en(rd_en), .raddr(raddr), .rvalid(rvalid2), .rdata(rdata2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] base, input logic [31:0] step);
        vec_t v;
        for (int i = 0; i < LANES; i++) v[i*LANE_W +: LANE_W] = base + step * i;
        return v;
    endfunction

    task automatic wr(input logic [AW-1:0] a, input vec_t d, input logic [LANES-1:0] s);
        wen = 1'b1; waddr = a; wdata = d; wstrb = s;
        tick();
        wen = 1'b0;
    endtask

    // Issue one read on all ports; check READ_LAT=1 after one edge, READ_LAT=2 after two.
    task automatic read3(input string name, input logic [AW-1:0] a0, a1, a2,
                         input vec_t e0, e1, e2);
        vec_t e [3];
        e = '{e0, e1, e2};
        rd_en = '1; raddr = {a2, a1, a0};
        tick();
        rd_en = '0;
        chk({name, " rvalid lat1"}, vec_t'(rvalid1), vec_t'(3'b111));
        chk({name, " rvalid lat2 early"}, vec_t'(rvalid2), '0);
        for (int p = 0; p < NRD; p++) chk($sformatf("%s lat1 p%0d", name, p), rdata1[p*VW +: VW], e[p]);
        tick();
        chk({name, " rvalid lat1 pulse"}, vec_t'(rvalid1), '0);
        chk({name, " rvalid lat2"}, vec_t'(rvalid2), vec_t'(3'b111));
        for (int p = 0; p < NRD; p++) begin
            chk($sformatf("%s lat1 hold p%0d", name, p), rdata1[p*VW +: VW], e[p]);
            chk($sformatf("%s lat2 p%0d", name, p), rdata2[p*VW +: VW], e[p]);
        end
    endtask

    task automatic wait_clear(input string name);
        int n1 = 0, n2 = 0, g = 0;
        tick();
        chk({name, " busy lat1 start"}, vec_t'(busy1), vec_t'(1'b1));
        chk({name, " busy lat2 start"}, vec_t'(busy2), vec_t'(1'b1));
        while ((busy1 || busy2) && g < 100) begin
            n1 += int'(busy1); n2 += int'(busy2); g++;
            tick();
        end
        chk({name, " busy cycles lat1"}, vec_t'(n1), vec_t'(DEPTH));
        chk({name, " busy cycles lat2"}, vec_t'(n2), vec_t'(DEPTH));
    endtask

    initial begin
        rvec_t tbl [4];
        vec_t  e5, e7, e9, e15, ef;
        int    n, g;

        // Reset state and automatic clear.
        repeat (3) tick();
        chk("rst busy", vec_t'({busy1, busy2}), '0);
        chk("rst rvalid", vec_t'({rvalid1, rvalid2}), '0);
        for (int p = 0; p < NRD; p++) begin
            chk($sformatf("rst rdata1 p%0d", p), rdata1[p*VW +: VW], '0);
            chk($sformatf("rst rdata2 p%0d", p), rdata2[p*VW +: VW], '0);
        end
        rst_n = 1'b1;
        wait_clear("rst clear");
        for (int a = 0; a < DEPTH; a += 3)
            read3($sformatf("zero a%0d", a), AW'(a), AW'((a + 1) % DEPTH), AW'((a + 2) % DEPTH), '0, '0, '0);

        // Writes with lane strobes.
        wr(4'd5, mkv(32'd1, 32'd1), '1);
        wr(4'd5, '1, 16'h00F0);
        wr(4'd9, mkv(32'h900, 32'd1), '1);
        wr(4'd7, mkv(32'h11, 32'd0), '1);
        wr(4'd15, mkv(32'hF0, 32'd1), 16'h8001);
        wr(4'd9, '1, 16'h0000);

        e5 = mkv(32'd1, 32'd1);
        e5[4*LANE_W +: 4*LANE_W] = '1;
        e9 = mkv(32'h900, 32'd1);
        e7 = mkv(32'h11, 32'd0);
        e15 = '0;
        e15[0 +: LANE_W] = 32'hF0;
        e15[15*LANE_W +: LANE_W] = 32'hFF;
        tbl[0] = '{a0: 4'd5,  a1: 4'd9,  a2: 4'd5,  e0: e5,  e1: e9,  e2: e5};
        tbl[1] = '{a0: 4'd0,  a1: 4'd15, a2: 4'd7,  e0: '0,  e1: e15, e2: e7};
        tbl[2] = '{a0: 4'd15, a1: 4'd15, a2: 4'd15, e0: e15, e1: e15, e2: e15};
        tbl[3] = '{a0: 4'd9,  a1: 4'd0,  a2: 4'd5,  e0: e9,  e1: '0,  e2: e5};
        for (int k = 0; k < 4; k++)
            read3($sformatf("tbl%0d", k), tbl[k].a0, tbl[k].a1, tbl[k].a2, tbl[k].e0, tbl[k].e1, tbl[k].e2);

        // Same-cycle write and read of addr 7.
        ef = e7;
        ef[0 +: LANE_W] = FWD ? 32'hA5 : 32'h11;
        wen = 1'b1; waddr = 4'd7; wdata = mkv(32'hA5, 32'd0); wstrb = 16'h0001;
        rd_en = 3'b001; raddr = {4'd0, 4'd0, 4'd7};
        tick();
        wen = 1'b0; rd_en = '0;
        chk("rdw lat1", rdata1[0 +: VW], ef);
        tick();
        chk("rdw lat2", rdata2[0 +: VW], ef);
        e7[0 +: LANE_W] = 32'hA5;
        read3("after rdw", 4'd7, 4'd7, 4'd0, e7, e7, '0);

        // Clear mid-traffic with wen/rd_en held high and a second clr_req during CLEAR.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        wen = 1'b1; waddr = 4'd3; wdata = '1; wstrb = '1;
        rd_en = '1; raddr = {4'd5, 4'd9, 4'd3};
        n = 0; g = 0;
        while (busy1 && g < 100) begin
            chk($sformatf("clr rvalid c%0d", n), vec_t'({rvalid1, rvalid2}), '0);
            n++; g++;
            clr_req = (n == 5);
            tick();
        end
        wen = 1'b0; rd_en = '0; clr_req = 1'b0;
        chk("clr busy cycles", vec_t'(n), vec_t'(DEPTH));
        read3("after clr", 4'd3, 4'd5, 4'd9, '0, '0, '0);

        // Reset dropped for one cycle at clr_ptr=8 restarts the clear.
        wr(4'd12, mkv(32'hC0, 32'd1), '1);
        wr(4'd2, mkv(32'h20, 32'd1), '1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst busy", vec_t'({busy1, busy2}), '0);
        rst_n = 1'b1;
        wait_clear("midrst clear");
        read3("after midrst", 4'd12, 4'd2, 4'd8, '0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
